// File: rtl/gpio_input_debounce.sv
// Per-bit 2-FF synchroniser and tick-based debounce for raw board inputs feeding gpio0_i.
// Optional sticky rise/fall edge flags when GPIO_INPUT_DEBOUNCE_EDGE_EN is defined.
module gpio_input_debounce #(
    parameter int              WIDTH        = 8,
    parameter int              CLK_FREQ_HZ  = 24000000,
    parameter int              TICK_HZ      = 1000,
    parameter int              STABLE_TICKS = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] db_o,
    output logic             tick_o,
`ifdef GPIO_INPUT_DEBOUNCE_EDGE_EN
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    input  logic [WIDTH-1:0] edge_clr_i,
`endif
    output logic             changed_o
);

    localparam int PRESCALE = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW       = $clog2(STABLE_TICKS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] db_q, db_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] flip_q, flip_d;
    logic             changed_q, changed_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        tick_d  = (presc_q == PRESC_LAST);
        db_d    = db_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == db_q[i]) begin
                // Agreement always restarts the count, even on a tick cycle.
                cnt_d[i] = '0;
            end else if (tick_q) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]  = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // flip_q marks bits that changed at the last edge; changed_o follows one cycle later.
        flip_d    = db_d ^ db_q;
        changed_d = |flip_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= RESET_VALUE;
            sync2_q   <= RESET_VALUE;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            db_q      <= RESET_VALUE;
            flip_q    <= '0;
            changed_q <= 1'b0;
            // NOTE: the counter array is small and must lose all progress on reset, so it is reset.
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            db_q      <= db_d;
            flip_q    <= flip_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign db_o      = db_q;
    assign tick_o    = tick_q;
    assign changed_o = changed_q;

`ifdef GPIO_INPUT_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    always_comb begin
        // Set terms are OR-ed after the clear so a same-cycle edge is never lost.
        rise_d = (rise_q & ~edge_clr_i) | (flip_q &  db_q);
        fall_d = (fall_q & ~edge_clr_i) | (flip_q & ~db_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`endif

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Directed self-checking bench for gpio_input_debounce (PRESCALE=10, STABLE_TICKS=3).
`timescale 1ns/1ps
module tb_gpio_input_debounce;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] raw_i = 8'h00;
    logic [7:0] db_o;
    logic       tick_o;
    logic       changed_o;
`ifdef GPIO_INPUT_DEBOUNCE_EDGE_EN
    logic [7:0] rise_o, fall_o;
    logic [7:0] edge_clr_i = 8'h00;
`endif

    int errors = 0;
    int checks = 0;

    gpio_input_debounce #(
        .WIDTH(8), .CLK_FREQ_HZ(100), .TICK_HZ(10), .STABLE_TICKS(3), .RESET_VALUE(8'h00)
    ) dut (
        .clock(clock),
        .reset(reset),
        .raw_i(raw_i),
        .db_o(db_o),
        .tick_o(tick_o),
`ifdef GPIO_INPUT_DEBOUNCE_EDGE_EN
        .rise_o(rise_o),
        .fall_o(fall_o),
        .edge_clr_i(edge_clr_i),
`endif
        .changed_o(changed_o)
    );

    always #5 clock = ~clock;

    // Advance one clock; sample and drive 1 ns after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Step until db_o[b] == v or 40 cycles elapse; n returns cycles waited.
    task automatic wait_db(input int b, input logic v, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (db_o[b] !== v && n < 40);
        checks++;
        if (db_o[b] !== v) begin
            errors++;
            $display("FAIL wait_db bit%0d: got %b after %0d cycles, expected %b", b, db_o[b], n, v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        raw_i = 8'h00;
        repeat (3) step();
        checks++;
        if (db_o !== 8'h00 || tick_o !== 1'b0 || changed_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: db=%h tick=%b changed=%b, expected 00/0/0", db_o, tick_o, changed_o);
        end
`ifdef GPIO_INPUT_DEBOUNCE_EDGE_EN
        checks++;
        if (rise_o !== 8'h00 || fall_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: rise=%h fall=%h, expected 00/00", rise_o, fall_o);
        end
`endif
        reset = 1'b0;
        for (int n = 1; n <= 35; n++) begin
            step();
            checks++;
            if (tick_o !== (n % 10 == 0)) begin
                errors++;
                $display("FAIL tick_phase cycle %0d: got %b, expected %b", n, tick_o, (n % 10 == 0));
            end
            checks++;
            if (db_o !== 8'h00 || changed_o !== 1'b0) begin
                errors++;
                $display("FAIL idle cycle %0d: db=%h changed=%b, expected 00/0", n, db_o, changed_o);
            end
        end
    endtask

    task automatic test_step();
        int n;
        raw_i = 8'h01;
        wait_db(0, 1'b1, n);
        checks++;
        if (n < 21 || n > 32) begin
            errors++;
            $display("FAIL step_latency: got %0d cycles, expected 21..32", n);
        end
        checks++;
        if (db_o !== 8'h01 || changed_o !== 1'b0) begin
            errors++;
            $display("FAIL step_flip: db=%h changed=%b, expected 01/0", db_o, changed_o);
        end
        step();
        checks++;
        if (changed_o !== 1'b1) begin
            errors++;
            $display("FAIL step_changed_pulse: got %b, expected 1", changed_o);
        end
        step();
        checks++;
        if (changed_o !== 1'b0) begin
            errors++;
            $display("FAIL step_changed_end: got %b, expected 0", changed_o);
        end
    endtask

    task automatic test_bounce();
        for (int r = 0; r < 4; r++) begin
            raw_i = 8'h03;
            for (int c = 0; c < 16; c++) begin
                if (c == 15) raw_i = 8'h01;
                step();
                checks++;
                if (db_o !== 8'h01 || changed_o !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce r%0d c%0d: db=%h changed=%b, expected 01/0", r, c, db_o, changed_o);
                end
            end
        end
        repeat (3) step();
    endtask

    task automatic test_multi();
        int n;
        raw_i = 8'hF1;
        wait_db(4, 1'b1, n);
        checks++;
        if (db_o !== 8'hF1) begin
            errors++;
            $display("FAIL multi_flip: db=%h, expected f1", db_o);
        end
        step();
        checks++;
        if (changed_o !== 1'b1) begin
            errors++;
            $display("FAIL multi_changed_pulse: got %b, expected 1", changed_o);
        end
        step();
        checks++;
        if (changed_o !== 1'b0) begin
            errors++;
            $display("FAIL multi_changed_single: got %b, expected 0", changed_o);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int ticks;
        raw_i = 8'h00;
        wait_db(0, 1'b0, n);
        checks++;
        if (db_o !== 8'h00) begin
            errors++;
            $display("FAIL all_fall: db=%h, expected 00", db_o);
        end
        repeat (3) step();
        raw_i = 8'h04;
        repeat (2) step();
        ticks = 0;
        for (int g = 0; g < 30 && ticks < 2; g++) begin
            if (tick_o === 1'b1) ticks++;
            if (ticks < 2) step();
        end
        step();
        checks++;
        if (ticks != 2 || db_o !== 8'h00) begin
            errors++;
            $display("FAIL pre_reset: ticks=%0d db=%h, expected 2/00", ticks, db_o);
        end
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (db_o !== 8'h00 || tick_o !== 1'b0 || changed_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: db=%h tick=%b changed=%b, expected 00/0/0", db_o, tick_o, changed_o);
        end
        reset = 1'b0;
        n = 0;
        do begin
            step();
            n++;
            checks++;
            if (tick_o !== (n % 10 == 0)) begin
                errors++;
                $display("FAIL post_reset_tick cycle %0d: got %b, expected %b", n, tick_o, (n % 10 == 0));
            end
        end while (db_o[2] !== 1'b1 && n < 40);
        checks++;
        if (db_o !== 8'h04 || n < 30 || n > 31) begin
            errors++;
            $display("FAIL post_reset_flip: db=%h after %0d cycles, expected 04 at 30..31", db_o, n);
        end
        repeat (2) step();
    endtask

`ifdef GPIO_INPUT_DEBOUNCE_EDGE_EN
    task automatic test_edges();
        int n;
        raw_i = 8'h0C;
        wait_db(3, 1'b1, n);
        checks++;
        if (rise_o[3] !== 1'b0) begin
            errors++;
            $display("FAIL rise_early: got %b, expected 0", rise_o[3]);
        end
        step();
        checks++;
        if (rise_o[3] !== 1'b1 || fall_o[3] !== 1'b0 || changed_o !== 1'b1) begin
            errors++;
            $display("FAIL rise_set: rise=%b fall=%b changed=%b, expected 1/0/1", rise_o[3], fall_o[3], changed_o);
        end
        raw_i = 8'h04;
        wait_db(3, 1'b0, n);
        step();
        checks++;
        if (rise_o[3] !== 1'b1 || fall_o[3] !== 1'b1) begin
            errors++;
            $display("FAIL fall_set: rise=%b fall=%b, expected 1/1", rise_o[3], fall_o[3]);
        end
        raw_i = 8'h0C;
        wait_db(3, 1'b1, n);
        edge_clr_i = 8'h08;
        step();
        edge_clr_i = 8'h00;
        checks++;
        if (rise_o[3] !== 1'b1 || fall_o[3] !== 1'b0) begin
            errors++;
            $display("FAIL set_beats_clear: rise=%b fall=%b, expected 1/0", rise_o[3], fall_o[3]);
        end
        edge_clr_i = 8'h08;
        step();
        edge_clr_i = 8'h00;
        checks++;
        if (rise_o[3] !== 1'b0 || fall_o[3] !== 1'b0) begin
            errors++;
            $display("FAIL clear_only: rise=%b fall=%b, expected 0/0", rise_o[3], fall_o[3]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_step();
        test_bounce();
        test_multi();
        test_reset_mid();
`ifdef GPIO_INPUT_DEBOUNCE_EDGE_EN
        test_edges();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
